// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: funnels TLBWR/TLBFILL/TLBRD and the INVTLB entry
// walk from the WB stage through the single TLB read port and single write port.
module tlb_maint_ctrl #(
   parameter  int TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [IW-1:0] req_index,
   input  logic [88:0]   req_entry,
   input  logic [4:0]    inv_op,
   input  logic [9:0]    inv_asid,
   input  logic [18:0]   inv_vppn,
   output logic [IW-1:0] tlb_r_index,
   input  logic [88:0]   tlb_r_entry,
   output logic          tlb_we,
   output logic [IW-1:0] tlb_w_index,
   output logic [88:0]   tlb_w_entry,
   output logic          done_valid,
   output logic [88:0]   done_entry,
   output logic [IW-1:0] done_index,
   output logic          done_err
);

   localparam logic [1:0] OP_WR   = 2'd0;
   localparam logic [1:0] OP_FILL = 2'd1;
   localparam logic [1:0] OP_RD   = 2'd2;
   localparam logic [1:0] OP_INV  = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ONE  = 2'd1;
   localparam logic [1:0] ST_WALK = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic [IW-1:0] IDX_LAST   = IW'(TLBNUM - 1);
   localparam logic [4:0]    INV_OP_MAX = 5'd6;

   logic [1:0]    state_r;
   logic [IW-1:0] fill_ptr_r;
   logic [IW-1:0] walk_cnt_r;
   logic [IW-1:0] idx_r;
   logic [1:0]    op_r;
   logic [88:0]   entry_r;
   logic [4:0]    inv_op_r;
   logic [9:0]    inv_asid_r;
   logic [18:0]   inv_vppn_r;
   logic [88:0]   done_entry_r;
   logic [IW-1:0] done_index_r;
   logic          done_err_r;
   logic          accept_s;
   logic          inv_bad_op_s;

   // Entry layout: e[88] ps[87:82] vppn[81:63] asid[62:53] g[52]; a 2MB page (ps=21) compares vppn[18:9] only
   function automatic logic inv_match_f(input logic [88:0] ent, input logic [4:0] op,
                                        input logic [9:0] asid, input logic [18:0] vppn);
      logic g_s;
      logic asid_hit_s;
      logic va_hit_s;
      logic sel_s;
      g_s        = ent[52];
      asid_hit_s = (ent[62:53] == asid);
      if (ent[87:82] == 6'd21) begin
         va_hit_s = (ent[81:72] == vppn[18:9]);
      end else begin
         va_hit_s = (ent[81:63] == vppn);
      end
      case (op)
         5'd0, 5'd1: sel_s = 1'b1;
         5'd2:       sel_s = g_s;
         5'd3:       sel_s = ~g_s;
         5'd4:       sel_s = ~g_s & asid_hit_s;
         5'd5:       sel_s = ~g_s & asid_hit_s & va_hit_s;
         5'd6:       sel_s = (g_s | asid_hit_s) & va_hit_s;
         default:    sel_s = 1'b0;
      endcase
      return ent[88] & sel_s;
   endfunction

   assign accept_s     = req_valid & (state_r == ST_IDLE);
   assign inv_bad_op_s = (inv_op_r > INV_OP_MAX);
   assign req_ready    = (state_r == ST_IDLE);
   assign done_valid   = (state_r == ST_RESP);
   assign done_entry   = done_entry_r;
   assign done_index   = done_index_r;
   assign done_err     = done_err_r;

   // Free-running FILL victim pointer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fill_ptr_r <= {IW{1'b0}};
      end else if (fill_ptr_r == IDX_LAST) begin
         fill_ptr_r <= {IW{1'b0}};
      end else begin
         fill_ptr_r <= fill_ptr_r + IW'(1);
      end
   end

   // Sequencer state, walk counter and request capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         walk_cnt_r <= {IW{1'b0}};
         idx_r      <= {IW{1'b0}};
         op_r       <= 2'd0;
         entry_r    <= 89'd0;
         inv_op_r   <= 5'd0;
         inv_asid_r <= 10'd0;
         inv_vppn_r <= 19'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r       <= req_op;
                  entry_r    <= req_entry;
                  inv_op_r   <= inv_op;
                  inv_asid_r <= inv_asid;
                  inv_vppn_r <= inv_vppn;
                  walk_cnt_r <= {IW{1'b0}};
                  idx_r      <= (req_op == OP_FILL) ? fill_ptr_r : req_index;
                  state_r    <= (req_op == OP_INV) ? ST_WALK : ST_ONE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ONE: begin
               state_r <= ST_RESP;
            end
            ST_WALK: begin
               if (inv_bad_op_s || (walk_cnt_r == IDX_LAST)) begin
                  walk_cnt_r <= {IW{1'b0}};
                  state_r    <= ST_RESP;
               end else begin
                  walk_cnt_r <= walk_cnt_r + IW'(1);
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Completion results held for the WB stage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         done_entry_r <= 89'd0;
         done_index_r <= {IW{1'b0}};
         done_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  done_err_r <= 1'b0;
               end
            end
            ST_ONE: begin
               done_index_r <= idx_r;
               if (op_r == OP_RD) begin
                  done_entry_r <= tlb_r_entry;
               end
            end
            ST_WALK: begin
               if (inv_bad_op_s) begin
                  done_err_r <= 1'b1;
               end
            end
            default: begin
               done_err_r <= done_err_r;
            end
         endcase
      end
   end

   // Port drive: the walk write depends on this cycle's read data, so it stays combinational
   always_comb begin
      tlb_r_index = {IW{1'b0}};
      tlb_we      = 1'b0;
      tlb_w_index = {IW{1'b0}};
      tlb_w_entry = 89'd0;
      case (state_r)
         ST_ONE: begin
            tlb_r_index = idx_r;
            if (op_r == OP_RD) begin
               tlb_we = 1'b0;
            end else begin
               tlb_we      = 1'b1;
               tlb_w_index = idx_r;
               tlb_w_entry = entry_r;
            end
         end
         ST_WALK: begin
            if (inv_bad_op_s) begin
               tlb_we = 1'b0;
            end else begin
               tlb_r_index = walk_cnt_r;
               tlb_w_index = walk_cnt_r;
               tlb_w_entry = {1'b0, tlb_r_entry[87:0]};
               tlb_we      = inv_match_f(tlb_r_entry, inv_op_r, inv_asid_r, inv_vppn_r);
            end
         end
         default: begin
            tlb_we = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl: a behavioural TLB array behind the ports,
// hand-computed expectations for each maintenance op.
module tb_tlb_maint_ctrl;

   localparam int TLBNUM = 16;
   localparam int IW     = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [IW-1:0] req_index;
   logic [88:0]   req_entry;
   logic [4:0]    inv_op;
   logic [9:0]    inv_asid;
   logic [18:0]   inv_vppn;
   logic [IW-1:0] tlb_r_index;
   logic [88:0]   tlb_r_entry;
   logic          tlb_we;
   logic [IW-1:0] tlb_w_index;
   logic [88:0]   tlb_w_entry;
   logic          done_valid;
   logic [88:0]   done_entry;
   logic [IW-1:0] done_index;
   logic          done_err;

   logic [88:0]       mem [TLBNUM];
   logic              pl_we;
   logic [IW-1:0]     pl_idx;
   logic [88:0]       pl_data;
   logic              clr_mon;
   int                wr_cnt;
   logic [TLBNUM-1:0] wr_mask;
   logic [IW-1:0]     m_fp;

   int total = 0;
   int bad   = 0;

   tlb_maint_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_index(req_index), .req_entry(req_entry),
      .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
      .done_valid(done_valid), .done_entry(done_entry),
      .done_index(done_index), .done_err(done_err)
   );

   always #5 clk = ~clk;

   assign tlb_r_entry = mem[tlb_r_index];

   // TLB array plus a log of which indices the controller wrote
   always @(posedge clk) begin
      if (pl_we) mem[pl_idx] <= pl_data;
      else if (tlb_we) mem[tlb_w_index] <= tlb_w_entry;
      if (clr_mon) begin
         wr_cnt  <= 0;
         wr_mask <= '0;
      end else if (tlb_we) begin
         wr_cnt <= wr_cnt + 1;
         wr_mask[tlb_w_index] <= 1'b1;
      end
   end

   // Expected FILL victim: counts edges since reset release
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_fp <= 4'd0;
      else m_fp <= m_fp + 4'd1;
   end

   task automatic check_val(input string tag, input logic [88:0] got, input logic [88:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [88:0] mk(input logic e, input logic [5:0] ps, input logic [18:0] vppn,
                                      input logic [9:0] asid, input logic g, input logic [19:0] ppn0);
      return {e, ps, vppn, asid, g, ppn0, 6'b010111, 20'h0F0F0, 6'b000011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int idx, input logic [88:0] data);
      pl_we   = 1'b1;
      pl_idx  = IW'(idx);
      pl_data = data;
      tick();
      pl_we = 1'b0;
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1;
      tick();
      clr_mon = 1'b0;
   endtask

   // Presents one request and returns in the first cycle after acceptance
   task automatic issue(input logic [1:0] op, input logic [IW-1:0] idx, input logic [88:0] ent,
                        input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vppn);
      req_op    = op;
      req_index = idx;
      req_entry = ent;
      inv_op    = iop;
      inv_asid  = asid;
      inv_vppn  = vppn;
      req_valid = 1'b1;
      check_val("ready_before_accept", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
   endtask

   // Cycle count since acceptance at which done_valid is seen (first post-accept cycle = 1)
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done_valid && lat < 40) begin
         check_val("busy_ready_low", req_ready, 1'b0);
         tick();
         lat++;
      end
   endtask

   logic [88:0]       ent_wr, ent_rd, ent_f1, ent_f2, e2, e4, e6;
   logic [TLBNUM-1:0] eb;
   int                lat;

   initial begin
      req_valid = 1'b0; req_op = 2'd0; req_index = '0; req_entry = 89'd0;
      inv_op = 5'd0; inv_asid = 10'd0; inv_vppn = 19'd0;
      pl_we = 1'b0; pl_idx = '0; pl_data = 89'd0; clr_mon = 1'b1;
      tick(); tick();

      check_val("rst_ready", req_ready, 1'b1);
      check_val("rst_we", tlb_we, 1'b0);
      check_val("rst_done_valid", done_valid, 1'b0);
      check_val("rst_done_entry", done_entry, 89'd0);
      check_val("rst_done_index", done_index, 4'd0);
      check_val("rst_done_err", done_err, 1'b0);
      check_val("rst_r_index", tlb_r_index, 4'd0);
      check_val("rst_w_index", tlb_w_index, 4'd0);
      check_val("rst_w_entry", tlb_w_entry, 89'd0);
      clr_mon = 1'b0;
      resetn  = 1'b1;

      // TLBWR to index 5
      ent_wr = mk(1'b1, 6'd12, 19'h12345, 10'h03A, 1'b0, 20'h54321);
      issue(2'd0, 4'd5, ent_wr, 5'd0, 10'd0, 19'd0);
      check_val("wr_we", tlb_we, 1'b1);
      check_val("wr_w_index", tlb_w_index, 4'd5);
      check_val("wr_w_entry", tlb_w_entry, ent_wr);
      check_val("wr_busy", req_ready, 1'b0);
      tick();
      check_val("wr_done_valid", done_valid, 1'b1);
      check_val("wr_done_index", done_index, 4'd5);
      check_val("wr_no_accept_in_done", req_ready, 1'b0);
      tick();
      check_val("wr_done_pulse", done_valid, 1'b0);
      check_val("wr_mem5", mem[5], ent_wr);

      // TLBRD of index 9
      ent_rd = mk(1'b1, 6'd12, 19'h00777, 10'h001, 1'b1, 20'hABCDE);
      preload(9, ent_rd);
      issue(2'd2, 4'd9, 89'd0, 5'd0, 10'd0, 19'd0);
      check_val("rd_we", tlb_we, 1'b0);
      check_val("rd_r_index", tlb_r_index, 4'd9);
      tick();
      check_val("rd_done_valid", done_valid, 1'b1);
      check_val("rd_done_entry", done_entry, ent_rd);
      check_val("rd_ppn0", {69'd0, done_entry[51:32]}, 89'hABCDE);
      check_val("rd_done_index", done_index, 4'd9);
      check_val("rd_we_resp", tlb_we, 1'b0);
      tick();

      // Two back-to-back TLBFILLs: victim 7 then 10
      ent_f1 = mk(1'b1, 6'd12, 19'h00111, 10'h011, 1'b0, 20'h11111);
      ent_f2 = mk(1'b1, 6'd12, 19'h00222, 10'h022, 1'b0, 20'h22222);
      for (int n = 0; n < 32 && m_fp != 4'd7; n++) tick();
      req_op = 2'd1; req_index = 4'd0; req_entry = ent_f1; req_valid = 1'b1;
      tick();
      req_entry = ent_f2;
      check_val("fill1_we", tlb_we, 1'b1);
      check_val("fill1_w_index", tlb_w_index, 4'd7);
      check_val("fill1_w_entry", tlb_w_entry, ent_f1);
      tick();
      check_val("fill1_done_valid", done_valid, 1'b1);
      check_val("fill1_done_index", done_index, 4'd7);
      tick();
      check_val("fill2_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      check_val("fill2_w_index", tlb_w_index, 4'd10);
      check_val("fill2_w_entry", tlb_w_entry, ent_f2);
      tick();
      check_val("fill2_done_index", done_index, 4'd10);
      tick();

      // INVTLB op 5: only entry 2 qualifies (4 is global, 6 carries a different ASID)
      e2 = mk(1'b1, 6'd12, 19'h00400, 10'h021, 1'b0, 20'h0AAAA);
      e4 = mk(1'b1, 6'd12, 19'h00400, 10'h021, 1'b1, 20'h0BBBB);
      e6 = mk(1'b1, 6'd21, 19'h005FF, 10'h033, 1'b0, 20'h0CCCC);
      for (int i = 0; i < TLBNUM; i++)
         preload(i, (i == 2) ? e2 : (i == 4) ? e4 : (i == 6) ? e6 : 89'd0);
      clear_mon();
      issue(2'd3, 4'd0, 89'd0, 5'd5, 10'h021, 19'h00400);
      wait_done(lat);
      check_val("inv5_latency", lat, 17);
      check_val("inv5_err", done_err, 1'b0);
      tick();
      check_val("inv5_wr_cnt", wr_cnt, 1);
      check_val("inv5_wr_mask", wr_mask, 16'h0004);
      check_val("inv5_mem2", mem[2], {1'b0, e2[87:0]});
      check_val("inv5_mem4", mem[4], e4);
      check_val("inv5_mem6", mem[6], e6);

      // INVTLB op 7 is rejected without touching the array
      clear_mon();
      issue(2'd3, 4'd0, 89'd0, 5'd7, 10'h021, 19'h00400);
      check_val("inv7_we", tlb_we, 1'b0);
      wait_done(lat);
      check_val("inv7_latency", lat, 2);
      check_val("inv7_err", done_err, 1'b1);
      tick();
      check_val("inv7_wr_cnt", wr_cnt, 0);

      // INVTLB op 0 clears every valid entry and drops the stale error
      for (int i = 0; i < TLBNUM; i++) preload(i, mk(1'b1, 6'd12, 19'(i), 10'(i), i[0], 20'(i)));
      clear_mon();
      issue(2'd3, 4'd0, 89'd0, 5'd0, 10'd0, 19'd0);
      check_val("inv0_err_cleared", done_err, 1'b0);
      wait_done(lat);
      check_val("inv0_latency", lat, 17);
      check_val("inv0_err", done_err, 1'b0);
      tick();
      check_val("inv0_wr_cnt", wr_cnt, 16);
      for (int i = 0; i < TLBNUM; i++) eb[i] = mem[i][88];
      check_val("inv0_e_bits", eb, 16'h0000);

      // INVTLB op 6: global or ASID hit, with 2MB pages compared on vppn[18:9]
      for (int i = 0; i < TLBNUM; i++)
         preload(i, (i == 0) ? mk(1'b1, 6'd21, 19'h005FF, 10'h055, 1'b1, 20'h1) :
                    (i == 1) ? mk(1'b1, 6'd12, 19'h005FF, 10'h021, 1'b0, 20'h2) :
                    (i == 2) ? mk(1'b1, 6'd21, 19'h00500, 10'h021, 1'b0, 20'h3) :
                    (i == 3) ? mk(1'b1, 6'd21, 19'h00400, 10'h022, 1'b0, 20'h4) : 89'd0);
      clear_mon();
      issue(2'd3, 4'd0, 89'd0, 5'd6, 10'h021, 19'h00400);
      wait_done(lat);
      check_val("inv6_latency", lat, 17);
      tick();
      check_val("inv6_wr_mask", wr_mask, 16'h0005);

      // Reset in the middle of an op 1 walk: five entries already cleared
      for (int i = 0; i < TLBNUM; i++) preload(i, mk(1'b1, 6'd12, 19'(i), 10'h001, 1'b1, 20'(i)));
      clear_mon();
      issue(2'd3, 4'd0, 89'd0, 5'd1, 10'd0, 19'd0);
      for (int n = 0; n < 5; n++) tick();
      resetn = 1'b0;
      #1;
      check_val("mid_rst_ready", req_ready, 1'b1);
      check_val("mid_rst_we", tlb_we, 1'b0);
      check_val("mid_rst_done_valid", done_valid, 1'b0);
      tick();
      check_val("mid_rst_idle", req_ready, 1'b1);
      check_val("mid_rst_we2", tlb_we, 1'b0);
      resetn = 1'b1;
      check_val("mid_rst_wr_cnt", wr_cnt, 5);
      for (int i = 0; i < TLBNUM; i++) eb[i] = mem[i][88];
      check_val("mid_rst_e_bits", eb, 16'hFFE0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
- Sequences all TLB maintenance traffic through the single TLB read port and single TLB write port: TLBWR, TLBFILL, TLBRD and multi-cycle INVTLB.
- Sits between the WB stage, which issues the request and stalls on ready/done, and the tlb array.
- INVTLB is executed as a walk over every entry: read, match, rewrite with E=0.
- TLBFILL victim index comes from an internal free-running counter.

Parameters:
- TLBNUM, 16, number of TLB entries; power of 2, 2..64. IW = clog2(TLBNUM).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  maintenance request from WB.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_op  in  2  0=TLBWR, 1=TLBFILL, 2=TLBRD, 3=INVTLB.
- req_index  in  IW  CSR.TLBIDX.Index, used for WR/RD.
- req_entry  in  89  packed entry for WR/FILL: {e,ps[5:0],vppn[18:0],asid[9:0],g,ppn0[19:0],plv0,mat0,d0,v0,ppn1[19:0],plv1,mat1,d1,v1}.
- inv_op  in  5  INVTLB op code.
- inv_asid  in  10  INVTLB rj ASID.
- inv_vppn  in  19  INVTLB rk VA[31:13].
- tlb_r_index  out  IW  read-port index.
- tlb_r_entry  in  89  read-port data, same packing, combinational from tlb_r_index.
- tlb_we  out  1  write strobe.
- tlb_w_index  out  IW  write index.
- tlb_w_entry  out  89  write data.
- done_valid  out  1  one-cycle pulse when the request completes.
- done_entry  out  89  registered TLBRD result, valid with done_valid.
- done_index  out  IW  index used (WR/FILL/RD).
- done_err  out  1  INVTLB op > 6; no entries modified.

Behaviour:
- Reset (async, resetn=0): state=IDLE, fill_ptr=0, walk_cnt=0. Outputs: req_ready=1, tlb_we=0, done_valid=0, done_entry=0, done_index=0, done_err=0, tlb_r_index=0, tlb_w_index=0, tlb_w_entry=0. Reset mid-walk abandons the walk; already-invalidated entries stay invalidated.
- fill_ptr: IW-bit counter, +1 every cycle, wraps TLBNUM-1 -> 0.
- Handshake: accept when req_valid && req_ready. Request fields are latched at acceptance. req_ready=1 only in IDLE. No new request is accepted in the same cycle as done_valid.
- State IDLE: on accept go to ONE (op 0/1/2) or WALK (op 3). On accept, latch idx = req_index (WR/RD) or fill_ptr value at accept (FILL).
- State ONE (1 cycle), by op:
  - WR/FILL: tlb_we=1, tlb_w_index=idx, tlb_w_entry=latched entry.
  - RD: tlb_r_index=idx; done_entry<=tlb_r_entry.
  - All ops: done_index<=idx. Next state RESP.
  - Latency from accept to done_valid: 2 cycles.
- State WALK: valid ops are inv_op 0..6.
  - If inv_op > 6: skip the walk, done_err<=1, go to RESP.
  - Otherwise walk_cnt starts at 0. Each cycle: tlb_r_index=walk_cnt; evaluate match on tlb_r_entry. If match, tlb_we=1 and tlb_w_index=walk_cnt. tlb_w_entry=tlb_r_entry with e forced to 0, all other fields unchanged.
  - walk_cnt increments each cycle; after the cycle where walk_cnt == TLBNUM-1, go to RESP with walk_cnt<=0.
  - INVTLB latency from accept to done_valid: TLBNUM+1 cycles.
- Match rules, all require e=1:
  - op 0,1: always.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 && asid==inv_asid.
  - op 5: g=0 && asid==inv_asid && va_hit.
  - op 6: (g=1 || asid==inv_asid) && va_hit.
  - va_hit: if ps==21, vppn[18:9]==inv_vppn[18:9]; otherwise vppn[18:0]==inv_vppn.
- State RESP: done_valid=1 for exactly one cycle, then go to IDLE. done_err is cleared on the next accept.
- tlb_we is never asserted outside ONE and WALK. At most one write per cycle.
- No flush input: once accepted, an operation always completes.

Test Plan:
- Reset: hold resetn=0 mid-WALK -> next cycle state IDLE, tlb_we=0, req_ready=1, done_valid=0; entries already cleared stay cleared.
- TLBWR: req_op=0, req_index=5, entry with vppn=0x12345, e=1 -> 1 cycle after accept tlb_we=1, w_index=5, w_entry==req_entry; 2 cycles after accept done_valid=1, done_index=5.
- TLBRD: preload entry 9 with ppn0=0xABCDE, accept req_op=2, index=9 -> done_entry.ppn0=0xABCDE, done_index=9; tlb_we stays 0 throughout.
- TLBFILL: accept when fill_ptr=7 -> write lands at index 7, done_index=7; second fill 3 cycles later lands at 10 (mod 16).
- INVTLB op 5, asid=0x21, vppn=0x00400; entries: 2 {g=0,asid=0x21,ps=12,vppn=0x00400}, 4 {same, g=1}, 6 {ps=21,vppn=0x005FF} -> exactly entry 2 written with e=0; done_valid 17 cycles after accept (TLBNUM=16); req_ready=0 for the whole walk.
- INVTLB op 7 -> no tlb_we, done_valid 2 cycles after accept with done_err=1. Next op 0 clears every e; 16 writes, done_err=0.
